clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Controller for the programmable clock divider path: owns the divide ratio, starts and stops the divided clock without runt pulses, and accepts run-time divisor changes through a valid/ready handshake. Changes apply only at output-period boundaries. The block sits between the configuration source and logic clocked by or enabled from `clk_out`. It generates `clk_out` as a registered, glitch-free fabric signal plus a rising-edge strobe.

## Interface
- `DIV_W`, 8, width of divisor.
- `DEFAULT_DIV`, 4, divisor loaded at reset (must be ≥ MIN_DIV).
- `clk_in` input 1: sole clock.
- `reset` input 1: synchronous, active-high.
- `en` input 1: run request; level-sensitive.
- `cfg_valid` input 1: new divisor offered.
- `cfg_div` input DIV_W: offered divisor N.
- `cfg_ready` output 1: controller can accept a divisor this cycle.
- `cfg_err` output 1: one-cycle pulse, offered divisor rejected (present only with `CLK_DIV_CTRL_ERR_EN`).
- `clk_out` output 1: divided clock, registered.
- `edge_tick` output 1: one-cycle pulse coincident with each `clk_out` 0→1 transition.
- `state` output 2: current FSM state, for debug.

The single clock is `clk_in`. `reset` is synchronous and active-high.

## Operation
- Active divisor N, counter `cnt` in 0..N-1, high count H = N − floor(N/2). For odd N, the extra cycle goes to the high phase.
- Each counting cycle: `next_cnt` = (cnt == N−1) ? 0 : cnt+1. Then `cnt` ← `next_cnt`, `clk_out` ← (`next_cnt` < H), `edge_tick` ← (`next_cnt` == 0).
- A wrap is any cycle with `next_cnt` == 0 while counting.
- States: IDLE=0, RUN=1, PEND=2, STOP=3.
  - IDLE: no counting, `cnt`=0, `clk_out`=0. On `en`=1, start counting with `next_cnt`=0 and go to RUN.
  - RUN: count. `en`=0 → STOP. Accepted valid divisor → PEND.
  - PEND: count. At wrap, load the pending divisor as N before computing outputs, so the new period starts high with the new H, then go to RUN. `en`=0 → STOP with the pending flag kept.
  - STOP: count. At the cycle that would wrap, go to IDLE with `cnt`←0, `clk_out`←0, `edge_tick`←0. If the pending flag is set, N ← pending on that transition.
  - STOP with `en` re-asserted: complete the stop to IDLE first, then restart on the next cycle.
- `cfg_ready` = 1 in IDLE and RUN only; it is a combinational decode of registered state.
- A handshake occurs when `cfg_valid` && `cfg_ready`. `cfg_div` is sampled on that edge.
  - In IDLE, N ← `cfg_div` on that edge.
  - In RUN, the value goes to the pending register.
- Invalid divisor (`cfg_div` < 2):
  - With the macro: the value is consumed, N and state are unchanged, and `cfg_err` pulses the following cycle.
  - Without the macro: the value is clamped to 2.
- If a handshake and `en` falling occur in the same RUN cycle, the divisor is stored as pending and the next state is STOP.
- Reset values: state=IDLE, N=DEFAULT_DIV, `cnt`=0, `clk_out`=0, `edge_tick`=0, `cfg_err`=0, pending flag=0. Reset mid-period drops `clk_out` on the next edge and discards any pending divisor.

## Timing
- Start: `en` first sampled high at edge k. `clk_out`=1 and `edge_tick`=1 after edge k.
- Output period is exactly N `clk_in` cycles: H high, N−H low.
- Divisor change latency: takes effect at the first wrap after acceptance, between 1 and N_old cycles. No partial period is ever emitted.
- Stop latency: `clk_out` stays low from the end of the current high phase. IDLE is reached at the period end, at most N cycles after `en` falls.
- All outputs are registered except `cfg_ready` and `state`, which come straight from the state register.

## Configuration
- `CLK_DIV_CTRL_ERR_EN` defined: `cfg_err` port exists, and divisors < 2 are rejected with a pulse.
- Undefined: no `cfg_err` port, and divisors < 2 are silently clamped to 2.

## Structure
- Package `clk_div_ctrl_pkg`:
  - state enum typedef (IDLE/RUN/PEND/STOP);
  - localparam MIN_DIV = 2.
- Sub-module `clk_div_core`:
  - contents: `cnt`, H computation, `clk_out`/`edge_tick` registers;
  - inputs: N, count, force_idle;
  - output: wrap indication.
- The FSM, handshake, pending register and error logic stay in `clk_div_ctrl`.

## Test plan
- Reset, `en`=1, N=4 → `clk_out` pattern 1100 repeating, `edge_tick` every 4 cycles, first tick after the edge where `en` is first sampled high.
- N=5 from IDLE via handshake, then `en`=1 → 11100 pattern (H=3); `cfg_ready` high throughout.
- Running N=4, offer 6 mid-period → `cfg_ready` low during PEND; remaining 4-cycle period completes; next period is 111000.
- Running N=4, drop `en` at cnt=1 → current period finishes, `clk_out` stays 0, state=IDLE within 3 cycles, no extra tick.
- With macro, offer `cfg_div`=1 → `cfg_err` pulse one cycle later, N unchanged. Without macro → period becomes 2 (10 pattern).
- Assert `reset` in PEND with N=8 → next edge: `clk_out`=0, state=IDLE, N=DEFAULT_DIV, pending divisor lost.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clk_div_ctrl divider controller.
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int MIN_DIV = 2;

  // A new divisor may only be taken while no change or stop is in flight.
  function automatic logic div_ready(input state_t s);
    return (s == IDLE) || (s == RUN);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and registered clk_out / edge_tick generation for one divisor N.
module clk_div_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_n,
  input  logic             count,
  input  logic             restart,
  input  logic             force_idle,
  output logic             wrap,
  output logic             clk_out,
  output logic             edge_tick
);

  logic [DIV_W-1:0] cnt_reg;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] high_cnt;
  logic             last_cnt;
  logic             clk_out_reg;
  logic             edge_tick_reg;

  // Odd divisors give the extra cycle to the high phase.
  always_comb begin
    high_cnt = div_n - (div_n >> 1);
    last_cnt = (cnt_reg == div_n - DIV_W'(1));
    cnt_next = (restart || last_cnt) ? '0 : cnt_reg + DIV_W'(1);
    wrap     = count && !restart && last_cnt;
  end

  always_ff @(posedge clk_in) begin
    if (reset || force_idle) begin
      cnt_reg       <= '0;
      clk_out_reg   <= 1'b0;
      edge_tick_reg <= 1'b0;
    end else if (count) begin
      cnt_reg       <= cnt_next;
      clk_out_reg   <= (cnt_next < high_cnt);
      edge_tick_reg <= (cnt_next == '0);
    end else begin
      cnt_reg       <= '0;
      clk_out_reg   <= 1'b0;
      edge_tick_reg <= 1'b0;
    end
  end

  assign clk_out   = clk_out_reg;
  assign edge_tick = edge_tick_reg;

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider controller: start/stop, boundary-aligned divisor changes.
// Define CLK_DIV_CTRL_ERR_EN to reject divisors below MIN_DIV with a cfg_err pulse.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
`ifdef CLK_DIV_CTRL_ERR_EN
  output logic             cfg_err,
`endif
  output logic             clk_out,
  output logic             edge_tick,
  output logic [1:0]       state
);

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DIV_W-1:0] pend_div_reg, pend_div_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [DIV_W-1:0] cfg_div_eff;
  logic             cfg_bad;
  logic             hs;
  logic             cfg_take;
  logic             count;
  logic             restart;
  logic             force_idle;
  logic             wrap;

  assign cfg_ready = div_ready(state_reg);
  assign state     = state_reg;
  assign hs        = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_div < DIV_W'(MIN_DIV));

`ifdef CLK_DIV_CTRL_ERR_EN
  logic cfg_err_reg;

  // A rejected value is still consumed by the handshake.
  assign cfg_take    = hs && !cfg_bad;
  assign cfg_div_eff = cfg_div;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= hs && cfg_bad;
    end
  end

  assign cfg_err = cfg_err_reg;
`else
  assign cfg_take    = hs;
  assign cfg_div_eff = cfg_bad ? DIV_W'(MIN_DIV) : cfg_div;
`endif

  always_comb begin
    state_next      = state_reg;
    div_next        = div_reg;
    pend_div_next   = pend_div_reg;
    pend_valid_next = pend_valid_reg;
    count           = 1'b0;
    restart         = 1'b0;
    force_idle      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_take) div_next = cfg_div_eff;
        if (en) begin
          count      = 1'b1;
          restart    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        count = 1'b1;
        if (cfg_take) begin
          pend_div_next   = cfg_div_eff;
          pend_valid_next = 1'b1;
          state_next      = PEND;
        end
        if (!en) state_next = STOP;
      end
      PEND: begin
        count = 1'b1;
        // The period starting at this wrap already uses the new divisor.
        if (wrap) begin
          div_next        = pend_div_reg;
          pend_valid_next = 1'b0;
          state_next      = en ? RUN : STOP;
        end else if (!en) begin
          state_next = STOP;
        end
      end
      STOP: begin
        count = 1'b1;
        if (wrap) begin
          force_idle = 1'b1;
          state_next = IDLE;
          if (pend_valid_reg) begin
            div_next        = pend_div_reg;
            pend_valid_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg      <= IDLE;
      div_reg        <= DIV_W'(DEFAULT_DIV);
      pend_div_reg   <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_reg        <= div_next;
      pend_div_reg   <= pend_div_next;
      pend_valid_reg <= pend_valid_next;
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk_in    (clk_in),
    .reset     (reset),
    .div_n     (div_reg),
    .count     (count),
    .restart   (restart),
    .force_idle(force_idle),
    .wrap      (wrap),
    .clk_out   (clk_out),
    .edge_tick (edge_tick)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: per-cycle expectations queued at drive time.
module tb_clk_div_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       clk_out;
  logic       edge_tick;
  logic [1:0] state;
`ifdef CLK_DIV_CTRL_ERR_EN
  logic       cfg_err;
`endif

  typedef struct {
    logic       c;
    logic       t;
    logic [1:0] s;
    logic       e;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_push   = 0;

  always #5 clk_in = ~clk_in;

  clk_div_ctrl #(
    .DIV_W(8),
    .DEFAULT_DIV(4)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
`ifdef CLK_DIV_CTRL_ERR_EN
    .cfg_err  (cfg_err),
`endif
    .clk_out  (clk_out),
    .edge_tick(edge_tick),
    .state    (state)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs for the next edge and queue what the outputs must be after it.
  task automatic cyc(input logic r, input logic e, input logic v, input logic [7:0] d,
                     input logic xc, input logic xt, input logic [1:0] xs, input logic xe);
    exp_t x;
    @(posedge clk_in);
    #2;
    reset     = r;
    en        = e;
    cfg_valid = v;
    cfg_div   = d;
    x.c   = xc;
    x.t   = xt;
    x.s   = xs;
    x.e   = xe;
    x.idx = n_push;
    n_push++;
    exp_q.push_back(x);
    $display("cyc %0d: rst=%0b en=%0b valid=%0b div=%0d -> exp clk_out=%0b tick=%0b state=%0d",
             x.idx, r, e, v, d, xc, xt, xs);
  endtask

  // Full running periods of divisor n: high for n - n/2 cycles, tick on the first.
  task automatic period(input int n, input int reps);
    int h;
    h = n - n / 2;
    for (int p = 0; p < reps; p++) begin
      for (int i = 0; i < n; i++) begin
        cyc(1'b0, 1'b1, 1'b0, 8'd0, (i < h), (i == 0), S_RUN, 1'b0);
      end
    end
  endtask

  always @(posedge clk_in) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check_val($sformatf("clk_out@%0d", x.idx), 32'(clk_out), 32'(x.c));
      check_val($sformatf("edge_tick@%0d", x.idx), 32'(edge_tick), 32'(x.t));
      check_val($sformatf("state@%0d", x.idx), 32'(state), 32'(x.s));
      check_val($sformatf("cfg_ready@%0d", x.idx), 32'(cfg_ready),
                32'((x.s == S_IDLE) || (x.s == S_RUN)));
`ifdef CLK_DIV_CTRL_ERR_EN
      check_val($sformatf("cfg_err@%0d", x.idx), 32'(cfg_err), 32'(x.e));
`endif
    end
  end

  initial begin
    logic [1:0] es;
    logic       ee;
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;

    // Reset, then start with the default divisor of 4: 1100.
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, S_IDLE, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, S_IDLE, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, S_IDLE, 1'b0);
    period(4, 3);

    // Drop en at cnt=1: period finishes low, IDLE at the period end, no extra tick.
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, S_RUN,  1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, S_RUN,  1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, S_STOP, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, S_STOP, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, S_IDLE, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, S_IDLE, 1'b0);

    // Load N=5 in IDLE, then run: 11100.
    cyc(1'b0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0, S_IDLE, 1'b0);
    period(5, 2);

    // Offer 6 mid-period; offers during PEND are ignored; next period is 111000.
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, S_RUN,  1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'd6, 1'b1, 1'b0, S_PEND, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'd9, 1'b1, 1'b0, S_PEND, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'd9, 1'b0, 1'b0, S_PEND, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, S_PEND, 1'b0);
    period(6, 2);

    // Offer an invalid divisor of 1 while running at N=6.
`ifdef CLK_DIV_CTRL_ERR_EN
    es = S_RUN;
    ee = 1'b1;
`else
    es = S_PEND;
    ee = 1'b0;
`endif
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, S_RUN, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0, es, ee);
    for (int i = 2; i < 6; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'd0, (i < 3), 1'b0, es, 1'b0);
    end
`ifdef CLK_DIV_CTRL_ERR_EN
    period(6, 1);
`else
    period(2, 3);
`endif

    // Reset mid-run, load N=8, reset again while a change to 3 is pending.
    cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, S_IDLE, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'd8, 1'b0, 1'b0, S_IDLE, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, S_RUN,  1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0, S_PEND, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, S_PEND, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, S_IDLE, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, S_IDLE, 1'b0);
    period(4, 2);

    // Handshake with en falling: stop carries divisor 2, en re-asserted restarts after IDLE.
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, S_RUN,  1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, S_STOP, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, S_STOP, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, S_STOP, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, S_IDLE, 1'b0);
    period(2, 3);

    @(posedge clk_in);
    #3;
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
